// File: rtl/or1200_genpc_fetch.sv
// Fetch-address generator feeding the instruction cache: sequential PC advance plus
// prioritised redirects, with a one-entry slot that parks redirects raised while the IC retries.
module or1200_genpc_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0100,
    parameter logic [31:0] EXC_VEC_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] icpu_adr_o,
    output logic        icpu_cycstb_o,
    output logic [3:0]  icpu_sel_o,
    output logic [3:0]  icpu_tag_o,
    input  logic        icpu_rty_i,
    input  logic        genpc_freeze,
    input  logic        if_stall,
    input  logic        genpc_refetch,
    input  logic        branch_taken,
    input  logic [29:0] branch_target,
    input  logic        except_start,
    input  logic [3:0]  except_type,
    input  logic        rfe,
    input  logic [31:0] epcr,
    input  logic        spr_npc_we,
    input  logic [31:0] spr_dat_i,
    output logic        redirect_busy
);

    typedef enum logic {IDLE, RUN} state_t;

    // Larger value wins when a new redirect meets a parked one.
    typedef enum logic [1:0] {
        SRC_BRANCH = 2'd0,
        SRC_RFE    = 2'd1,
        SRC_EXC    = 2'd2,
        SRC_NPC    = 2'd3
    } src_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [29:0] r_pc;
    logic [29:0] r_pend;
    src_t        r_pend_src;
    logic        r_pend_v;
    logic        r_tag_first;

    logic        w_redir;
    logic [29:0] w_tgt;
    src_t        w_src;
    logic        w_advance;
    logic        w_load;
    logic        w_keep_pend;
    logic        w_unused;

    // Word-address sources only; byte offsets of epcr/spr_dat_i are dropped.
    assign w_unused = ^{epcr[1:0], spr_dat_i[1:0]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_redir = 1'b1;
        w_tgt   = branch_target;
        w_src   = SRC_BRANCH;
        if (spr_npc_we) begin
            w_tgt = spr_dat_i[31:2];
            w_src = SRC_NPC;
        end else if (except_start) begin
            w_tgt = {EXC_VEC_BASE[31:12], except_type, 6'b00_0000};
            w_src = SRC_EXC;
        end else if (rfe) begin
            w_tgt = epcr[31:2];
            w_src = SRC_RFE;
        end else if (!branch_taken) begin
            w_redir = 1'b0;
        end
    end

    assign w_advance   = (r_state == RUN) && !genpc_freeze && !if_stall && !icpu_rty_i && !genpc_refetch;
    assign w_load      = !icpu_rty_i && (w_redir || r_pend_v);
    assign w_keep_pend = r_pend_v && (r_pend_src > w_src);

    always_comb begin
        w_state_next = r_state;
        if (r_state == IDLE) begin
            w_state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc        <= RESET_PC[31:2];
            r_pend      <= '0;
            r_pend_src  <= SRC_BRANCH;
            r_pend_v    <= 1'b0;
            r_tag_first <= 1'b1;
        end else begin
            if (w_redir && !icpu_rty_i) begin
                r_pc     <= w_tgt;
                r_pend_v <= 1'b0;
            end else if (w_redir) begin
                if (!w_keep_pend) begin
                    r_pend     <= w_tgt;
                    r_pend_src <= w_src;
                    r_pend_v   <= 1'b1;
                end
            end else if (r_pend_v && !icpu_rty_i) begin
                r_pc     <= r_pend;
                r_pend_v <= 1'b0;
            end else if (!genpc_refetch && w_advance) begin
                r_pc <= r_pc + 30'd1;
            end
            r_tag_first <= (r_state == IDLE) || w_load;
        end
    end

    assign icpu_adr_o    = {r_pc, 2'b00};
    assign icpu_cycstb_o = (r_state == RUN);
    assign icpu_sel_o    = 4'hF;
    assign icpu_tag_o    = r_tag_first ? 4'h1 : 4'h0;
    assign redirect_busy = r_pend_v;

endmodule

// File: tb/tb_or1200_genpc_fetch.sv
// Directed bench for or1200_genpc_fetch: reset, stalls, retry parking, redirect priority and wrap.
module tb_or1200_genpc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] icpu_adr_o;
    logic        icpu_cycstb_o;
    logic [3:0]  icpu_sel_o;
    logic [3:0]  icpu_tag_o;
    logic        icpu_rty_i;
    logic        genpc_freeze;
    logic        if_stall;
    logic        genpc_refetch;
    logic        branch_taken;
    logic [29:0] branch_target;
    logic        except_start;
    logic [3:0]  except_type;
    logic        rfe;
    logic [31:0] epcr;
    logic        spr_npc_we;
    logic [31:0] spr_dat_i;
    logic        redirect_busy;

    int checks = 0;
    int errors = 0;

    or1200_genpc_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .icpu_adr_o    (icpu_adr_o),
        .icpu_cycstb_o (icpu_cycstb_o),
        .icpu_sel_o    (icpu_sel_o),
        .icpu_tag_o    (icpu_tag_o),
        .icpu_rty_i    (icpu_rty_i),
        .genpc_freeze  (genpc_freeze),
        .if_stall      (if_stall),
        .genpc_refetch (genpc_refetch),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .except_start  (except_start),
        .except_type   (except_type),
        .rfe           (rfe),
        .epcr          (epcr),
        .spr_npc_we    (spr_npc_we),
        .spr_dat_i     (spr_dat_i),
        .redirect_busy (redirect_busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        branch_taken = 1'b0;
        except_start = 1'b0;
        rfe          = 1'b0;
        spr_npc_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        icpu_rty_i = 1'b0; genpc_freeze = 1'b0; if_stall = 1'b0; genpc_refetch = 1'b0;
        branch_target = '0; except_type = '0; epcr = '0; spr_dat_i = '0;
        clear_redirects();
        step(); step();
        checks++; if (icpu_adr_o !== 32'h100) begin errors++; $display("FAIL reset_adr got %h exp %h", icpu_adr_o, 32'h100); end
        checks++; if (icpu_cycstb_o !== 1'b0) begin errors++; $display("FAIL reset_cycstb got %b exp 0", icpu_cycstb_o); end
        checks++; if (icpu_tag_o !== 4'h1) begin errors++; $display("FAIL reset_tag got %h exp 1", icpu_tag_o); end
        checks++; if (redirect_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", redirect_busy); end
        checks++; if (icpu_sel_o !== 4'hF) begin errors++; $display("FAIL sel got %h exp f", icpu_sel_o); end
        rst = 1'b1;
        step();
        checks++; if (icpu_cycstb_o !== 1'b1) begin errors++; $display("FAIL run_cycstb got %b exp 1", icpu_cycstb_o); end
        checks++; if (icpu_adr_o !== 32'h100) begin errors++; $display("FAIL run_first_adr got %h exp %h", icpu_adr_o, 32'h100); end
        checks++; if (icpu_tag_o !== 4'h1) begin errors++; $display("FAIL run_first_tag got %h exp 1", icpu_tag_o); end
        step();
        checks++; if (icpu_adr_o !== 32'h104) begin errors++; $display("FAIL seq_104 got %h exp %h", icpu_adr_o, 32'h104); end
        checks++; if (icpu_tag_o !== 4'h0) begin errors++; $display("FAIL seq_tag got %h exp 0", icpu_tag_o); end
        step();
        checks++; if (icpu_adr_o !== 32'h108) begin errors++; $display("FAIL seq_108 got %h exp %h", icpu_adr_o, 32'h108); end
    endtask

    task automatic test_stalls();
        genpc_freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (icpu_adr_o !== 32'h108) begin errors++; $display("FAIL freeze_hold%0d got %h exp %h", i, icpu_adr_o, 32'h108); end
        end
        genpc_freeze = 1'b0;
        step();
        checks++; if (icpu_adr_o !== 32'h10C) begin errors++; $display("FAIL freeze_release got %h exp %h", icpu_adr_o, 32'h10C); end
        if_stall = 1'b1;
        step();
        checks++; if (icpu_adr_o !== 32'h10C) begin errors++; $display("FAIL if_stall_hold got %h exp %h", icpu_adr_o, 32'h10C); end
        if_stall = 1'b0; genpc_refetch = 1'b1;
        step();
        checks++; if (icpu_adr_o !== 32'h10C) begin errors++; $display("FAIL refetch_hold got %h exp %h", icpu_adr_o, 32'h10C); end
        genpc_refetch = 1'b0;
    endtask

    task automatic test_retry_branch();
        icpu_rty_i = 1'b1; branch_taken = 1'b1; branch_target = 30'h800;
        step();
        checks++; if (icpu_adr_o !== 32'h10C) begin errors++; $display("FAIL rty_hold got %h exp %h", icpu_adr_o, 32'h10C); end
        checks++; if (redirect_busy !== 1'b1) begin errors++; $display("FAIL rty_busy got %b exp 1", redirect_busy); end
        clear_redirects();
        step();
        checks++; if (icpu_adr_o !== 32'h10C) begin errors++; $display("FAIL rty_hold2 got %h exp %h", icpu_adr_o, 32'h10C); end
        icpu_rty_i = 1'b0;
        step();
        checks++; if (icpu_adr_o !== 32'h2000) begin errors++; $display("FAIL pend_apply got %h exp %h", icpu_adr_o, 32'h2000); end
        checks++; if (icpu_tag_o !== 4'h1) begin errors++; $display("FAIL pend_tag got %h exp 1", icpu_tag_o); end
        checks++; if (redirect_busy !== 1'b0) begin errors++; $display("FAIL pend_busy got %b exp 0", redirect_busy); end
        step();
        checks++; if (icpu_adr_o !== 32'h2004) begin errors++; $display("FAIL after_pend got %h exp %h", icpu_adr_o, 32'h2004); end
    endtask

    task automatic test_priority();
        except_start = 1'b1; except_type = 4'h5; branch_taken = 1'b1; branch_target = 30'h1000;
        step();
        checks++; if (icpu_adr_o !== 32'h500) begin errors++; $display("FAIL exc_over_branch got %h exp %h", icpu_adr_o, 32'h500); end
        checks++; if (icpu_tag_o !== 4'h1) begin errors++; $display("FAIL exc_tag got %h exp 1", icpu_tag_o); end
        clear_redirects();
        rfe = 1'b1; epcr = 32'h0000_1237; branch_taken = 1'b1;
        step();
        checks++; if (icpu_adr_o !== 32'h1234) begin errors++; $display("FAIL rfe_over_branch got %h exp %h", icpu_adr_o, 32'h1234); end
        clear_redirects();
        step();
        checks++; if (icpu_adr_o !== 32'h1238) begin errors++; $display("FAIL rfe_advance got %h exp %h", icpu_adr_o, 32'h1238); end
    endtask

    task automatic test_pending_replace();
        icpu_rty_i = 1'b1; branch_taken = 1'b1; branch_target = 30'hC00;
        step();
        clear_redirects();
        except_start = 1'b1; except_type = 4'h5;
        step();
        clear_redirects();
        branch_taken = 1'b1; branch_target = 30'hC00;
        step();
        clear_redirects();
        checks++; if (icpu_adr_o !== 32'h1238) begin errors++; $display("FAIL slot_hold got %h exp %h", icpu_adr_o, 32'h1238); end
        icpu_rty_i = 1'b0;
        step();
        checks++; if (icpu_adr_o !== 32'h500) begin errors++; $display("FAIL slot_exc got %h exp %h", icpu_adr_o, 32'h500); end
        // A live redirect with rty low supersedes a parked one.
        icpu_rty_i = 1'b1; branch_taken = 1'b1; branch_target = 30'hC00;
        step();
        clear_redirects();
        icpu_rty_i = 1'b0; rfe = 1'b1; epcr = 32'h0000_4000;
        step();
        clear_redirects();
        checks++; if (icpu_adr_o !== 32'h4000) begin errors++; $display("FAIL new_discards got %h exp %h", icpu_adr_o, 32'h4000); end
        checks++; if (redirect_busy !== 1'b0) begin errors++; $display("FAIL new_discards_busy got %b exp 0", redirect_busy); end
        step();
        checks++; if (icpu_adr_o !== 32'h4004) begin errors++; $display("FAIL no_stale_pend got %h exp %h", icpu_adr_o, 32'h4004); end
    endtask

    task automatic test_wrap_and_reset();
        spr_npc_we = 1'b1; spr_dat_i = 32'hFFFF_FFFF; except_start = 1'b1;
        step();
        clear_redirects();
        checks++; if (icpu_adr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL npc_write got %h exp %h", icpu_adr_o, 32'hFFFF_FFFC); end
        step();
        checks++; if (icpu_adr_o !== 32'h0) begin errors++; $display("FAIL wrap got %h exp %h", icpu_adr_o, 32'h0); end
        icpu_rty_i = 1'b1; branch_taken = 1'b1; branch_target = 30'h3;
        step();
        clear_redirects();
        checks++; if (redirect_busy !== 1'b1) begin errors++; $display("FAIL busy_before_rst got %b exp 1", redirect_busy); end
        icpu_rty_i = 1'b0; rst = 1'b0;
        step();
        checks++; if (icpu_adr_o !== 32'h100) begin errors++; $display("FAIL midrst_adr got %h exp %h", icpu_adr_o, 32'h100); end
        checks++; if (redirect_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", redirect_busy); end
        checks++; if (icpu_cycstb_o !== 1'b0) begin errors++; $display("FAIL midrst_cycstb got %b exp 0", icpu_cycstb_o); end
        rst = 1'b1;
        step();
        checks++; if (icpu_cycstb_o !== 1'b1 || icpu_adr_o !== 32'h100) begin errors++; $display("FAIL midrst_run got %b/%h exp 1/%h", icpu_cycstb_o, icpu_adr_o, 32'h100); end
        step();
        checks++; if (icpu_adr_o !== 32'h104) begin errors++; $display("FAIL midrst_seq got %h exp %h", icpu_adr_o, 32'h104); end
    endtask

    initial begin
        test_reset();
        test_stalls();
        test_retry_branch();
        test_priority();
        test_pending_replace();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
